// File: rtl/mc_control.sv
// Multi-cycle main control FSM for the multi-cycle MIPS datapath.
// Decodes op/funct one state per cycle and drives ALUOp, operand selects,
// flag write and all datapath write enables; waits on mem_ready for memory.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   op, funct        IR[31:26], IR[5:0]
//   alu_zero         ALU zero flag (branch compare)
//   mem_ready        memory completes the current access this cycle
//   mem_rd, mem_we   memory read / write request
//   iord             address select (0 = PC, 1 = ALUOut)
//   ir_we, pc_we, reg_we, flag_we   write enables
//   pc_src, reg_dst, mem_to_reg     datapath muxes
//   alu_src_a, alu_src_b, alu_op    ALU operand selects and operation
//   illegal          sticky undecoded-instruction flag
//   state            current state, for debug

`ifndef ALU_OP_ADD
`define ALU_OP_ADD  3'd0
`define ALU_OP_SUB  3'd1
`define ALU_OP_AND  3'd2
`define ALU_OP_OR   3'd3
`define ALU_OP_LESS 3'd4
`define ALU_OP_B    3'd5
`endif

module mc_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic       flag_we,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WB   = 4'd6,
        MEM_WR   = 4'd7,
        WB_R     = 4'd8,
        WB_I     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        TRAP     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    state_t cur;
    logic   illegal_q;

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_ADDU) || (f == FN_SUB) ||
               (f == FN_SUBU) || (f == FN_AND) || (f == FN_OR) ||
               (f == FN_SLT);
    endfunction

    function automatic state_t decode_next(input logic [5:0] o,
                                           input logic [5:0] f);
        state_t n;
        n = TRAP;
        case (o)
            OP_RTYPE: n = funct_ok(f) ? EXEC_R : TRAP;
            OP_ADDI, OP_ADDIU,
            OP_ORI, OP_LUI:  n = EXEC_I;
            OP_LW, OP_SW:    n = MEM_ADDR;
            OP_BEQ:          n = BRANCH;
            OP_J, OP_JAL:    n = JUMP;
            default:         n = TRAP;
        endcase
        return n;
    endfunction

    // State register and sticky illegal flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            case (cur)
                FETCH:    if (mem_ready) cur <= DECODE;
                DECODE: begin
                    cur <= decode_next(op, funct);
                    if (decode_next(op, funct) == TRAP)
                        illegal_q <= 1'b1;
                end
                EXEC_R:   cur <= WB_R;
                EXEC_I:   cur <= WB_I;
                MEM_ADDR: cur <= (op == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:   if (mem_ready) cur <= MEM_WB;
                MEM_WB:   cur <= FETCH;
                MEM_WR:   if (mem_ready) cur <= FETCH;
                WB_R:     cur <= FETCH;
                WB_I:     cur <= FETCH;
                BRANCH:   cur <= FETCH;
                JUMP:     cur <= FETCH;
                TRAP:     cur <= TRAP;
                default: begin
                    // Unused encodings are treated as a fault.
                    cur       <= TRAP;
                    illegal_q <= 1'b1;
                end
            endcase
        end
    end

    assign state   = cur;
    assign illegal = illegal_q;

    // Output decode; rst forces every request and enable low at once,
    // even though the state register itself clears asynchronously too.
    always_comb begin
        mem_rd     = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        flag_we    = 1'b0;
        pc_src     = 2'b00;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = `ALU_OP_ADD;
        if (!rst) begin
            case (cur)
                FETCH: begin
                    mem_rd    = 1'b1;
                    alu_src_b = 2'b01;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                DECODE: begin
                    alu_src_b = 2'b10;
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    flag_we   = 1'b1;
                    case (funct)
                        FN_ADD, FN_ADDU: alu_op = `ALU_OP_ADD;
                        FN_SUB, FN_SUBU: alu_op = `ALU_OP_SUB;
                        FN_AND:          alu_op = `ALU_OP_AND;
                        FN_OR:           alu_op = `ALU_OP_OR;
                        FN_SLT:          alu_op = `ALU_OP_LESS;
                        default:         alu_op = `ALU_OP_ADD;
                    endcase
                end
                EXEC_I: begin
                    alu_src_a = 1'b1;
                    flag_we   = 1'b1;
                    case (op)
                        OP_ORI: begin
                            alu_src_b = 2'b11;
                            alu_op    = `ALU_OP_OR;
                        end
                        OP_LUI: begin
                            alu_src_b = 2'b11;
                            alu_op    = `ALU_OP_B;
                        end
                        default: begin
                            alu_src_b = 2'b10;
                            alu_op    = `ALU_OP_ADD;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_RD: begin
                    mem_rd = 1'b1;
                    iord   = 1'b1;
                end
                MEM_WB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 2'b01;
                end
                MEM_WR: begin
                    mem_we = 1'b1;
                    iord   = 1'b1;
                end
                WB_R: begin
                    reg_we  = 1'b1;
                    reg_dst = 2'b01;
                end
                WB_I: begin
                    reg_we = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = `ALU_OP_SUB;
                    pc_src    = 2'b01;
                    pc_we     = alu_zero;
                    flag_we   = 1'b1;
                end
                JUMP: begin
                    pc_src = 2'b10;
                    pc_we  = 1'b1;
                    if (op == OP_JAL) begin
                        reg_we     = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed testbench for mc_control: per-cycle expected control words are
// queued as stimulus is applied and compared when the cycle is sampled.

`ifndef ALU_OP_ADD
`define ALU_OP_ADD  3'd0
`define ALU_OP_SUB  3'd1
`define ALU_OP_AND  3'd2
`define ALU_OP_OR   3'd3
`define ALU_OP_LESS 3'd4
`define ALU_OP_B    3'd5
`endif

module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_rd, mem_we, iord, ir_we, pc_we, reg_we, flag_we;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic       alu_src_a, illegal;
    logic [2:0] alu_op;
    logic [3:0] state;

    mc_control dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
        .flag_we(flag_we), .pc_src(pc_src), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       ill;
        logic       rd;
        logic       we;
        logic       io;
        logic       irw;
        logic       pcw;
        logic       rgw;
        logic       flw;
        logic [1:0] psrc;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic       sa;
        logic [1:0] sb;
        logic [2:0] aop;
    } ctl_t;

    ctl_t exp_q[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    function automatic ctl_t zero(input logic [3:0] s);
        ctl_t c;
        c     = '0;
        c.st  = s;
        c.aop = `ALU_OP_ADD;
        return c;
    endfunction

    function automatic ctl_t e_fetch(input logic rdy);
        ctl_t c;
        c     = zero(4'd0);
        c.rd  = 1'b1;
        c.sb  = 2'b01;
        c.irw = rdy;
        c.pcw = rdy;
        return c;
    endfunction

    function automatic ctl_t e_decode();
        ctl_t c;
        c    = zero(4'd1);
        c.sb = 2'b10;
        return c;
    endfunction

    function automatic ctl_t e_exec_r(input logic [2:0] a);
        ctl_t c;
        c     = zero(4'd2);
        c.sa  = 1'b1;
        c.flw = 1'b1;
        c.aop = a;
        return c;
    endfunction

    function automatic ctl_t e_exec_i(input logic [1:0] b,
                                      input logic [2:0] a);
        ctl_t c;
        c     = zero(4'd3);
        c.sa  = 1'b1;
        c.flw = 1'b1;
        c.sb  = b;
        c.aop = a;
        return c;
    endfunction

    function automatic ctl_t e_mem_addr();
        ctl_t c;
        c    = zero(4'd4);
        c.sa = 1'b1;
        c.sb = 2'b10;
        return c;
    endfunction

    function automatic ctl_t e_mem_rd();
        ctl_t c;
        c    = zero(4'd5);
        c.rd = 1'b1;
        c.io = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_mem_wb();
        ctl_t c;
        c     = zero(4'd6);
        c.rgw = 1'b1;
        c.m2r = 2'b01;
        return c;
    endfunction

    function automatic ctl_t e_mem_wr();
        ctl_t c;
        c    = zero(4'd7);
        c.we = 1'b1;
        c.io = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_wb(input logic r);
        ctl_t c;
        c      = zero(r ? 4'd8 : 4'd9);
        c.rgw  = 1'b1;
        c.rdst = r ? 2'b01 : 2'b00;
        return c;
    endfunction

    function automatic ctl_t e_branch(input logic z);
        ctl_t c;
        c      = zero(4'd10);
        c.sa   = 1'b1;
        c.aop  = `ALU_OP_SUB;
        c.psrc = 2'b01;
        c.pcw  = z;
        c.flw  = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_jump(input logic link);
        ctl_t c;
        c      = zero(4'd11);
        c.psrc = 2'b10;
        c.pcw  = 1'b1;
        if (link) begin
            c.rgw  = 1'b1;
            c.rdst = 2'b10;
            c.m2r  = 2'b10;
        end
        return c;
    endfunction

    function automatic ctl_t e_trap();
        ctl_t c;
        c     = zero(4'd15);
        c.ill = 1'b1;
        return c;
    endfunction

    function automatic ctl_t observe();
        ctl_t c;
        c = {state, illegal, mem_rd, mem_we, iord, ir_we, pc_we,
             reg_we, flag_we, pc_src, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, alu_op};
        return c;
    endfunction

    task automatic compare_now(input string tag);
        ctl_t e, o;
        e = exp_q.pop_front();
        o = observe();
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    // One clock cycle: inputs already driven, expectation queued now,
    // compared on the falling edge, then advance past the rising edge.
    task automatic cyc(input string tag, input logic rdy, input ctl_t e);
        mem_ready = rdy;
        exp_q.push_back(e);
        @(negedge clk);
        compare_now(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] o, input logic [5:0] f);
        op    = o;
        funct = f;
    endtask

    initial begin
        #2;
        exp_q.push_back(zero(4'd0));
        compare_now("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // add
        instr(6'b000000, 6'b100000);
        cyc("add_fetch", 1'b1, e_fetch(1'b1));
        cyc("add_dec", 1'b1, e_decode());
        cyc("add_exec", 1'b1, e_exec_r(`ALU_OP_ADD));
        cyc("add_wb", 1'b1, e_wb(1'b1));

        // sub with one fetch wait; mem_ready low in DECODE is ignored
        instr(6'b000000, 6'b100010);
        cyc("sub_fwait", 1'b0, e_fetch(1'b0));
        cyc("sub_fetch", 1'b1, e_fetch(1'b1));
        cyc("sub_dec", 1'b0, e_decode());
        cyc("sub_exec", 1'b0, e_exec_r(`ALU_OP_SUB));
        cyc("sub_wb", 1'b1, e_wb(1'b1));

        // slt and and
        instr(6'b000000, 6'b101010);
        cyc("slt_fetch", 1'b1, e_fetch(1'b1));
        cyc("slt_dec", 1'b1, e_decode());
        cyc("slt_exec", 1'b1, e_exec_r(`ALU_OP_LESS));
        cyc("slt_wb", 1'b1, e_wb(1'b1));
        instr(6'b000000, 6'b100100);
        cyc("and_fetch", 1'b1, e_fetch(1'b1));
        cyc("and_dec", 1'b1, e_decode());
        cyc("and_exec", 1'b1, e_exec_r(`ALU_OP_AND));
        cyc("and_wb", 1'b1, e_wb(1'b1));

        // lw with two wait cycles in MEM_RD
        instr(6'b100011, 6'b000000);
        cyc("lw_fetch", 1'b1, e_fetch(1'b1));
        cyc("lw_dec", 1'b1, e_decode());
        cyc("lw_addr", 1'b1, e_mem_addr());
        cyc("lw_wait1", 1'b0, e_mem_rd());
        cyc("lw_wait2", 1'b0, e_mem_rd());
        cyc("lw_rd", 1'b1, e_mem_rd());
        cyc("lw_wb", 1'b1, e_mem_wb());

        // sw with one wait cycle in MEM_WR
        instr(6'b101011, 6'b000000);
        cyc("sw_fetch", 1'b1, e_fetch(1'b1));
        cyc("sw_dec", 1'b1, e_decode());
        cyc("sw_addr", 1'b1, e_mem_addr());
        cyc("sw_wait", 1'b0, e_mem_wr());
        cyc("sw_wr", 1'b1, e_mem_wr());

        // beq taken then not taken
        instr(6'b000100, 6'b000000);
        alu_zero = 1'b1;
        cyc("beq1_fetch", 1'b1, e_fetch(1'b1));
        cyc("beq1_dec", 1'b1, e_decode());
        cyc("beq1_br", 1'b1, e_branch(1'b1));
        alu_zero = 1'b0;
        cyc("beq0_fetch", 1'b1, e_fetch(1'b1));
        cyc("beq0_dec", 1'b1, e_decode());
        cyc("beq0_br", 1'b1, e_branch(1'b0));

        // ori, lui, addi
        instr(6'b001101, 6'b000000);
        cyc("ori_fetch", 1'b1, e_fetch(1'b1));
        cyc("ori_dec", 1'b1, e_decode());
        cyc("ori_exec", 1'b1, e_exec_i(2'b11, `ALU_OP_OR));
        cyc("ori_wb", 1'b1, e_wb(1'b0));
        instr(6'b001111, 6'b000000);
        cyc("lui_fetch", 1'b1, e_fetch(1'b1));
        cyc("lui_dec", 1'b1, e_decode());
        cyc("lui_exec", 1'b1, e_exec_i(2'b11, `ALU_OP_B));
        cyc("lui_wb", 1'b1, e_wb(1'b0));
        instr(6'b001000, 6'b000000);
        cyc("addi_fetch", 1'b1, e_fetch(1'b1));
        cyc("addi_dec", 1'b1, e_decode());
        cyc("addi_exec", 1'b1, e_exec_i(2'b10, `ALU_OP_ADD));
        cyc("addi_wb", 1'b1, e_wb(1'b0));

        // j, jal
        instr(6'b000010, 6'b000000);
        cyc("j_fetch", 1'b1, e_fetch(1'b1));
        cyc("j_dec", 1'b1, e_decode());
        cyc("j_jump", 1'b1, e_jump(1'b0));
        instr(6'b000011, 6'b000000);
        cyc("jal_fetch", 1'b1, e_fetch(1'b1));
        cyc("jal_dec", 1'b1, e_decode());
        cyc("jal_jump", 1'b1, e_jump(1'b1));
        cyc("jal_back", 1'b1, e_fetch(1'b1));

        // illegal op -> TRAP for 10 cycles
        instr(6'b111111, 6'b000000);
        cyc("trap_dec", 1'b1, e_decode());
        for (int i = 0; i < 10; i++)
            cyc("trap_hold", i[0], e_trap());

        // async reset out of TRAP
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(zero(4'd0));
        compare_now("rst_trap");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // async reset during a FETCH wait drops mem_rd at once
        instr(6'b000000, 6'b100000);
        cyc("fw_wait", 1'b0, e_fetch(1'b0));
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(zero(4'd0));
        compare_now("rst_fwait");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("post_rst", 1'b1, e_fetch(1'b1));
        cyc("post_dec", 1'b1, e_decode());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
